// File: rtl/pattern_gen_checker.sv
// Loopback stimulus/check engine: generates a burst of words on a valid/ready stream
// and independently regenerates the same sequence to score the returned stream.
module pattern_gen_checker #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'hA300_0000),
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] MODE_INC  = 2'd0;
  localparam logic [1:0] MODE_DEC  = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;
  localparam logic [1:0] MODE_LFSR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [1:0]          mode_q;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    tx_cnt;
  logic [CNT_W-1:0]    rx_cnt;
  logic [DATA_W-1:0]   exp_q;
  logic [TO_W-1:0]     idle_cnt;

  logic [DATA_W-1:0]   load_c;
  logic [TO_W-1:0]     idle_nxt_c;
  logic                rx_accept_c;
  logic                tx_xfer_c;
  logic                complete_c;
  logic                expire_c;

  // One generator step; shared by the tx generator and the expected-word generator.
  function automatic logic [DATA_W-1:0] gen_step(input logic [1:0] m,
                                                 input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    case (m)
      MODE_INC:  r = d + DATA_W'(1);
      MODE_DEC:  r = d - DATA_W'(1);
      MODE_WALK: r = {d[DATA_W-2:0], d[DATA_W-1]};
      MODE_LFSR: r = d[0] ? ((d >> 1) ^ LFSR_TAPS) : (d >> 1);
      default:   r = d;
    endcase
    return r;
  endfunction

  // First word of a burst: walking-one always starts at 1, LFSR cannot start locked at 0.
  always_comb begin
    load_c = seed;
    if (mode == MODE_WALK)
      load_c = DATA_W'(1);
    else if ((mode == MODE_LFSR) && (seed == '0))
      load_c = DATA_W'(1);
  end

  assign tx_xfer_c   = (state == S_RUN) && tx_valid && tx_ready;
  assign rx_accept_c = (state == S_RUN) && rx_valid && (rx_cnt != len_q);
  assign idle_nxt_c  = idle_cnt + TO_W'(1);
  assign complete_c  = (tx_cnt == len_q) && (rx_cnt == len_q);
  assign expire_c    = !rx_accept_c && (idle_nxt_c == TO_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mode_q   <= '0;
      len_q    <= '0;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      exp_q    <= '0;
      idle_cnt <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q   <= mode;
            len_q    <= burst_len;
            tx_data  <= load_c;
            exp_q    <= load_c;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            idle_cnt <= '0;
            err_cnt  <= '0;
            timeout  <= 1'b0;
            if (burst_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_RUN;
              busy     <= 1'b1;
              tx_valid <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (tx_xfer_c) begin
            tx_cnt   <= tx_cnt + CNT_W'(1);
            tx_data  <= gen_step(mode_q, tx_data);
            tx_valid <= ((tx_cnt + CNT_W'(1)) != len_q);
          end

          if (rx_accept_c) begin
            rx_cnt   <= rx_cnt + CNT_W'(1);
            exp_q    <= gen_step(mode_q, exp_q);
            idle_cnt <= '0;
            if ((rx_data != exp_q) && (err_cnt != '1))
              err_cnt <= err_cnt + CNT_W'(1);
          end else begin
            idle_cnt <= idle_nxt_c;
          end

          // Normal completion takes precedence over a coincident timeout.
          if (complete_c) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            tx_valid <= 1'b0;
          end else if (expire_c) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            tx_valid <= 1'b0;
            timeout  <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_gen_checker.sv
// Scoreboard bench for pattern_gen_checker: expected tx words are queued when a burst is
// launched and popped on each observed tx handshake; accepted tx words are looped back as rx.
module tb_pattern_gen_checker;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  burst_len;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  err_cnt;

  int n_tests;
  int n_fail;

  logic [DATA_W-1:0] sb[$];

  pattern_gen_checker #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .LFSR_TAPS(32'hA300_0000),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .burst_len(burst_len),
    .seed     (seed),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_next(input logic [31:0] d);
    logic [31:0] r;
    r = d >> 1;
    if (d[0]) r = r ^ 32'hA300_0000;
    return r;
  endfunction

  // Launch a burst and run it to completion with loopback; one rx beat per tx beat, one cycle later.
  task automatic run_burst(input logic [1:0] m, input logic [15:0] len, input logic [31:0] sd,
                           input int rdy_mode, input int rx_limit, input int corrupt_idx,
                           input int spur_cyc, output int done_cnt, output int last_rx_cyc,
                           output int done_cyc);
    logic [31:0] lb[$];
    logic [31:0] exp_w;
    int rx_sent;
    int post;
    bit fin;
    done_cnt = 0; last_rx_cyc = -1; done_cyc = -1; rx_sent = 0; post = 0; fin = 1'b0;
    mode = m; burst_len = len; seed = sd; start = 1'b1;
    @(posedge clk); @(negedge clk);
    // Inputs changed after the start edge must not disturb the burst.
    start = 1'b0; mode = ~m; burst_len = len + 16'd3; seed = ~sd;
    n_tests++;
    if (tx_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_beat: tx_valid=%b busy=%b required 1 1", tx_valid, busy);
    end
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      start = (cyc == spur_cyc);
      case (rdy_mode)
        1:       tx_ready = !(cyc == 1 || cyc == 2);
        2:       tx_ready = (cyc % 3) != 2;
        default: tx_ready = 1'b1;
      endcase
      if (lb.size() > 0 && rx_sent < rx_limit) begin
        rx_valid = 1'b1;
        rx_data  = lb.pop_front() ^ ((rx_sent == corrupt_idx) ? 32'h1 : 32'h0);
        last_rx_cyc = cyc;
        rx_sent++;
      end else begin
        rx_valid = 1'b0;
        rx_data  = $urandom;
      end
      if (rdy_mode == 1 && (cyc == 1 || cyc == 2)) begin
        n_tests++;
        if (tx_data !== 32'd4 || tx_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold: cyc %0d tx_data=%h tx_valid=%b required 00000004 1",
                   cyc, tx_data, tx_valid);
        end
      end
      if (tx_valid && tx_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tx: cyc %0d tx_data=%h required no beat", cyc, tx_data);
        end else begin
          exp_w = sb.pop_front();
          if (tx_data !== exp_w) begin
            n_fail++;
            $display("FAIL tx_word: cyc %0d tx_data=%h required %h", cyc, tx_data, exp_w);
          end
        end
        lb.push_back(tx_data);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0) begin
        post++;
        if (post > 3) fin = 1'b1;
      end
      @(posedge clk); @(negedge clk);
    end
    start = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL burst_done_bound: done never seen within cycle budget");
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: %0d words left, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic check_end(input string name, input int done_cnt, input logic [15:0] exp_err,
                           input logic exp_to);
    n_tests++;
    if (done_cnt != 1 || err_cnt !== exp_err || timeout !== exp_to || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end: done_pulses=%0d err_cnt=%0d timeout=%b busy=%b required 1 %0d %b 0",
               name, done_cnt, err_cnt, timeout, busy, exp_err, exp_to);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = '0; burst_len = '0; seed = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (tx_data !== '0 || tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        timeout !== 1'b0 || err_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: tx_data=%h tx_valid=%b busy=%b done=%b timeout=%b err=%0d required all 0",
               tx_data, tx_valid, busy, done, timeout, err_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_inc();
    int dc, lr, dcy;
    sb.push_back(32'hFFFF_FFFE); sb.push_back(32'hFFFF_FFFF);
    sb.push_back(32'h0000_0000); sb.push_back(32'h0000_0001);
    run_burst(2'd0, 16'd4, 32'hFFFF_FFFE, 0, 1000, -1, -1, dc, lr, dcy);
    check_end("inc", dc, 16'd0, 1'b0);
  endtask

  task automatic test_walking();
    int dc, lr, dcy;
    for (int i = 0; i < 34; i++) sb.push_back(32'h1 << (i % 32));
    run_burst(2'd2, 16'd34, 32'hDEAD_BEEF, 2, 1000, -1, -1, dc, lr, dcy);
    check_end("walking", dc, 16'd0, 1'b0);
  endtask

  task automatic test_lfsr();
    int dc, lr, dcy;
    logic [31:0] w;
    w = 32'h1;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(w);
      w = lfsr_next(w);
    end
    run_burst(2'd3, 16'd8, 32'h0, 0, 1000, 3, -1, dc, lr, dcy);
    check_end("lfsr", dc, 16'd1, 1'b0);
  endtask

  task automatic test_stall_dec();
    int dc, lr, dcy;
    for (int i = 0; i < 6; i++) sb.push_back(32'd5 - 32'(i));
    run_burst(2'd1, 16'd6, 32'd5, 1, 1000, -1, -1, dc, lr, dcy);
    check_end("stall_dec", dc, 16'd0, 1'b0);
  endtask

  task automatic test_timeout();
    int dc, lr, dcy;
    for (int i = 0; i < 8; i++) sb.push_back(32'h0000_1000 + 32'(i));
    run_burst(2'd0, 16'd8, 32'h0000_1000, 0, 5, -1, -1, dc, lr, dcy);
    check_end("timeout", dc, 16'd0, 1'b1);
    // done is seen at the negedge following the edge 16 clocks after the 5th rx beat's edge
    n_tests++;
    if (dcy - lr != 17) begin
      n_fail++;
      $display("FAIL timeout_latency: done %0d cycles after 5th rx, required 17", dcy - lr);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (timeout !== 1'b1 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL timeout_sticky: timeout=%b err_cnt=%0d required 1 0", timeout, err_cnt);
    end
  endtask

  task automatic test_start_ignored();
    int dc, lr, dcy;
    for (int i = 0; i < 6; i++) sb.push_back(32'd100 + 32'(i));
    run_burst(2'd0, 16'd6, 32'd100, 0, 1000, -1, 2, dc, lr, dcy);
    check_end("start_ignored", dc, 16'd0, 1'b0);
  endtask

  task automatic test_zero_len();
    mode = 2'd0; burst_len = '0; seed = 32'h55; start = 1'b1; tx_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (done !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_done: done=%b tx_valid=%b busy=%b required 1 0 0", done, tx_valid, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_after: done=%b tx_valid=%b required 0 0", done, tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    mode = 2'd0; burst_len = 16'd10; seed = 32'h0; start = 1'b1; tx_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (tx_data !== '0 || tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        timeout !== 1'b0 || err_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: tx_data=%h tx_valid=%b busy=%b done=%b timeout=%b err=%0d required all 0",
               tx_data, tx_valid, busy, done, timeout, err_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_tests++;
    if (dones != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: done pulses=%0d busy=%b required 0 0", dones, busy);
    end
    tx_ready = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_inc();
    test_walking();
    test_timeout();
    test_lfsr();
    test_stall_dec();
    test_start_ignored();
    test_zero_len();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
